// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD timer controller.
//   timer_state_t : controller state encoding
//   BCD_MAX       : largest legal BCD digit value
//   bcd_clamp()   : clamps a nibble to a legal BCD digit (values above 9 become 9)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer cascade.
//   clk, reset : clock and asynchronous active-high reset
//   en         : apply one step this cycle (increment, or decrement when down)
//   down       : count direction
//   ld, ld_val : synchronous load, takes priority over en
//   q          : current digit value
//   term       : combinational; digit is at 9 (up) or 0 (down), so a step here carries/borrows
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       down,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       term
);

  logic [3:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (en) begin
      if (down) begin
        r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
      end else begin
        r_q <= (r_q >= BCD_MAX) ? 4'd0 : r_q + 4'd1;
      end
    end
  end

  assign q    = r_q;
  assign term = down ? (r_q == 4'd0) : (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch / countdown sequencer for a cascade of NDIGITS BCD digits.
// Divides clk by PRESCALE into count ticks and steps the digit chain up or down.
//   clk, reset        : clock, asynchronous active-high reset
//   start/stop        : begin/resume and pause commands
//   clear/load        : return to IDLE with digits zeroed or loaded (clamped) from load_value
//   mode_down         : direction, sampled when start is accepted from IDLE or DONE
//   digits            : registered BCD count, nibble i = digit i
//   running/done      : decoded from the state register (RUN / DONE)
//   tick              : 1-cycle pulse with every counting update of digits
//   overflow          : 1-cycle pulse with the up-count wrap all-9 -> all-0
// Command priority: clear > load > stop > start; any command suppresses a same-cycle step.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_value,
  input  logic                 mode_down,
  output logic [4*NDIGITS-1:0] digits,
  output logic                 running,
  output logic                 done,
  output logic                 tick,
  output logic                 overflow
);

  localparam int unsigned          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]        PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [4*NDIGITS-1:0] VAL_ONE  = (4*NDIGITS)'(1);

  timer_state_t r_state, w_state_d;
  logic [PW-1:0] r_pre, w_pre_d;
  logic          r_dir, w_dir_d;
  logic          r_tick, w_tick_d;
  logic          r_ovf, w_ovf_d;

  logic                 w_step;
  logic                 w_ld;
  logic [4*NDIGITS-1:0] w_ld_val;
  logic [4*NDIGITS-1:0] w_ld_clamped;
  logic [4*NDIGITS-1:0] w_digits;
  logic [NDIGITS-1:0]   w_term;
  logic [NDIGITS-1:0]   w_en;

  // Digit cascade: a digit steps only when every lower digit is at its terminal value.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign w_en[i] = w_step;
    end else begin : g_upper
      assign w_en[i] = w_step & (&w_term[i-1:0]);
    end

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (w_en[i]),
      .down   (r_dir),
      .ld     (w_ld),
      .ld_val (w_ld_val[4*i +: 4]),
      .q      (w_digits[4*i +: 4]),
      .term   (w_term[i])
    );
  end

  always_comb begin
    w_ld_clamped = '0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      w_ld_clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pre   <= w_pre_d;
      r_dir   <= w_dir_d;
      r_tick  <= w_tick_d;
      r_ovf   <= w_ovf_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pre_d   = r_pre;
    w_dir_d   = r_dir;
    w_tick_d  = 1'b0;
    w_ovf_d   = 1'b0;
    w_step    = 1'b0;
    w_ld      = 1'b0;
    w_ld_val  = '0;

    if (clear) begin
      w_state_d = IDLE;
      w_pre_d   = '0;
      w_ld      = 1'b1;
    end else if (load) begin
      w_state_d = IDLE;
      w_pre_d   = '0;
      w_ld      = 1'b1;
      w_ld_val  = w_ld_clamped;
    end else if (stop) begin
      // Prescaler holds so a resume continues the partial tick period.
      if (r_state == RUN) begin
        w_state_d = PAUSE;
      end
    end else if (start && (r_state != RUN)) begin
      if (r_state == PAUSE) begin
        w_state_d = RUN;
      end else begin
        w_dir_d   = mode_down;
        w_pre_d   = '0;
        // Counting down from zero has nothing to do: finish immediately, no tick.
        w_state_d = (mode_down && (w_digits == '0)) ? DONE : RUN;
      end
    end else if (r_state == RUN) begin
      if (r_pre == PRE_LAST) begin
        w_pre_d  = '0;
        w_step   = 1'b1;
        w_tick_d = 1'b1;
        if (!r_dir) begin
          w_ovf_d = &w_term;
        end else if (w_digits == VAL_ONE) begin
          w_state_d = DONE;
        end
      end else begin
        w_pre_d = r_pre + PW'(1);
      end
    end
  end

  assign digits   = w_digits;
  assign running  = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign tick     = r_tick;
  assign overflow = r_ovf;

endmodule
